serdesphy_ana_pll_loop_filter: RTL and testbench

//  Digital PI loop filter for the PLL. Upstream of the PLL VCO: integrates PFD up/dn error on the

---
 rtl/serdesphy_ana_pll_loop_filter_if.sv | 19 +
 rtl/serdesphy_ana_pll_loop_filter.sv | 174 +++++++++++++++++
 tb/tb_serdesphy_ana_pll_loop_filter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serdesphy_ana_pll_loop_filter_if.sv
// Loop-filter control/status bundle between the PLL controller and the PI loop filter.
interface serdesphy_ana_pll_loop_filter_if;
    logic       enable;
    logic       vco_ready;
    logic       pfd_up;
    logic       pfd_dn;
    logic [7:0] vco_control;
    logic       locked;

    modport master (
        output enable, vco_ready, pfd_up, pfd_dn,
        input  vco_control, locked
    );

    modport slave (
        input  enable, vco_ready, pfd_up, pfd_dn,
        output vco_control, locked
    );
endinterface

// File: rtl/serdesphy_ana_pll_loop_filter.sv
// Digital PI loop filter with acquisition/tracking FSM and lock detector for the PLL VCO.
// Optional: SERDESPHY_PLL_LF_GEARSHIFT_EN raises gains (4*KI, 2*KP) while acquiring.
module serdesphy_ana_pll_loop_filter #(
    parameter int unsigned FRAC_W    = 8,
    parameter int unsigned KP        = 4,
    parameter int unsigned KI        = 16,
    parameter int unsigned INIT_CODE = 128,
    parameter int unsigned LOCK_WIN  = 64,
    parameter int unsigned LOCK_TOL  = 4,
    parameter int unsigned LOCK_CNT  = 4
) (
    input logic                            clk,
    input logic                            rst_n,
    serdesphy_ana_pll_loop_filter_if.slave lf
);
    localparam int unsigned ACC_W  = 8 + FRAC_W;
    localparam int unsigned SUM_W  = ACC_W + 2;
    localparam int unsigned WIN_W  = $clog2(LOCK_WIN);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(INIT_CODE) << FRAC_W;
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

    localparam logic [1:0] StOff     = 2'd0;
    localparam logic [1:0] StWaitVco = 2'd1;
    localparam logic [1:0] StAcquire = 2'd2;
    localparam logic [1:0] StTrack   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        code_q, code_d;
    logic              locked_q, locked_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic signed [7:0] net_q, net_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic signed [1:0]       err;
    logic [SUM_W-1:0]        ki_eff;
    logic [10:0]             kp_eff;
    logic signed [SUM_W-1:0] acc_sum;
    logic [ACC_W-1:0]        acc_n;
    logic signed [10:0]      code_sum;
    logic [7:0]              code_n;
    logic signed [8:0]       net_sum, net_abs;
    logic signed [7:0]       net_sat;
    logic                    win_end, win_good;
    logic [GOOD_W-1:0]       good_inc;

`ifdef SERDESPHY_PLL_LF_GEARSHIFT_EN
    assign ki_eff = (state_q == StAcquire) ? SUM_W'(4 * KI) : SUM_W'(KI);
    assign kp_eff = (state_q == StAcquire) ? 11'(2 * KP) : 11'(KP);
`else
    assign ki_eff = SUM_W'(KI);
    assign kp_eff = 11'(KP);
`endif

    // up&dn together cancel to zero error
    assign err = (lf.pfd_up && !lf.pfd_dn) ? 2'sd1 :
                 (lf.pfd_dn && !lf.pfd_up) ? -2'sd1 : 2'sd0;

    always_comb begin
        unique case (err)
            2'sd1:   acc_sum = $signed({2'b00, acc_q}) + $signed(ki_eff);
            -2'sd1:  acc_sum = $signed({2'b00, acc_q}) - $signed(ki_eff);
            default: acc_sum = $signed({2'b00, acc_q});
        endcase
        if (acc_sum < 0)                           acc_n = '0;
        else if (acc_sum > $signed({2'b00, ACC_MAX})) acc_n = ACC_MAX;
        else                                       acc_n = acc_sum[ACC_W-1:0];

        unique case (err)
            2'sd1:   code_sum = $signed({3'b000, acc_n[ACC_W-1:FRAC_W]}) + $signed(kp_eff);
            -2'sd1:  code_sum = $signed({3'b000, acc_n[ACC_W-1:FRAC_W]}) - $signed(kp_eff);
            default: code_sum = $signed({3'b000, acc_n[ACC_W-1:FRAC_W]});
        endcase
        if (code_sum < 0)           code_n = 8'd0;
        else if (code_sum > 11'sd255) code_n = 8'd255;
        else                        code_n = code_sum[7:0];
    end

    always_comb begin
        net_sum  = $signed({net_q[7], net_q}) + $signed({{7{err[1]}}, err});
        net_abs  = (net_sum < 0) ? -net_sum : net_sum;
        net_sat  = (net_sum > 9'sd127) ? 8'sd127 :
                   (net_sum < -9'sd128) ? -8'sd128 : net_sum[7:0];
        win_end  = (win_q == WIN_W'(LOCK_WIN - 1));
        win_good = ($unsigned(net_abs) <= 9'(LOCK_TOL));
        good_inc = (good_q == GOOD_W'(LOCK_CNT)) ? good_q : good_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        code_d   = code_q;
        locked_d = locked_q;
        win_d    = win_q;
        net_d    = net_q;
        good_d   = good_q;
        if (!lf.enable) begin
            state_d  = StOff;
            acc_d    = ACC_INIT;
            code_d   = 8'(INIT_CODE);
            locked_d = 1'b0;
            win_d    = '0;
            net_d    = '0;
            good_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d  = StWaitVco;
                    locked_d = 1'b0;
                end
                StWaitVco: begin
                    locked_d = 1'b0;
                    win_d    = '0;
                    net_d    = '0;
                    good_d   = '0;
                    if (lf.vco_ready) state_d = StAcquire;
                end
                default: begin
                    if (!lf.vco_ready) begin
                        // loop frozen, code kept so reacquisition starts from last estimate
                        state_d  = StWaitVco;
                        locked_d = 1'b0;
                        win_d    = '0;
                        net_d    = '0;
                        good_d   = '0;
                    end else begin
                        acc_d  = acc_n;
                        code_d = code_n;
                        win_d  = win_end ? '0 : win_q + 1'b1;
                        net_d  = win_end ? '0 : net_sat;
                        if (win_end) begin
                            if (win_good) begin
                                good_d = good_inc;
                                if (state_q == StAcquire && good_inc == GOOD_W'(LOCK_CNT)) begin
                                    state_d  = StTrack;
                                    locked_d = 1'b1;
                                end
                            end else begin
                                good_d   = '0;
                                state_d  = StAcquire;
                                locked_d = 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            acc_q    <= ACC_INIT;
            code_q   <= 8'(INIT_CODE);
            locked_q <= 1'b0;
            win_q    <= '0;
            net_q    <= '0;
            good_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            code_q   <= code_d;
            locked_q <= locked_d;
            win_q    <= win_d;
            net_q    <= net_d;
            good_q   <= good_d;
        end
    end

    assign lf.vco_control = code_q;
    assign lf.locked      = locked_q;
endmodule

// File: tb/tb_serdesphy_ana_pll_loop_filter.sv
// Scoreboard bench for the PLL loop filter: directed vectors push expected outputs, monitor checks.
module tb_serdesphy_ana_pll_loop_filter;
    logic clk = 1'b0;
    logic rst_n;
    int   edges = 0;
    int   total = 0;
    int   bad = 0;
    int   track_code;

`ifdef SERDESPHY_PLL_LF_GEARSHIFT_EN
    localparam int KP_ACQ = 8;
`else
    localparam int KP_ACQ = 4;
`endif

    typedef struct {
        int         at_edge;
        string      name;
        logic [7:0] code;
        logic       lock;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;

    serdesphy_ana_pll_loop_filter_if lf ();

    serdesphy_ana_pll_loop_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lf    (lf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            if (sbq[0].at_edge < edges) begin
                cur = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL %s: check missed, edge %0d now %0d", cur.name, cur.at_edge, edges);
            end else if (sbq[0].at_edge == edges) begin
                cur = sbq.pop_front();
                total += 2;
                if (lf.vco_control !== cur.code) begin
                    bad++;
                    $display("FAIL %s code: got %0d want %0d", cur.name, lf.vco_control, cur.code);
                end
                if (lf.locked !== cur.lock) begin
                    bad++;
                    $display("FAIL %s locked: got %0b want %0b", cur.name, lf.locked, cur.lock);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int code, input logic lock);
        exp_t e;
        e.at_edge = edges;
        e.name    = name;
        e.code    = 8'(code);
        e.lock    = lock;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        lf.enable    = 1'b0;
        lf.vco_ready = 1'b0;
        lf.pfd_up    = 1'b0;
        lf.pfd_dn    = 1'b0;
        e.at_edge = 2; e.name = "reset"; e.code = 8'd128; e.lock = 1'b0;
        sbq.push_back(e);
        tick(3);
        rst_n = 1'b1;

        // VCO not ready: loop frozen regardless of error
        lf.enable = 1'b1;
        lf.pfd_up = 1'b1;
        tick(1);  chk("t1_off_wait", 128, 0);
        tick(19); chk("t1_wait_20", 128, 0);

`ifdef SERDESPHY_PLL_LF_GEARSHIFT_EN
        lf.pfd_up = 1'b0;
        lf.vco_ready = 1'b1;
        tick(1);   chk("t5_acq_entry", 128, 0);
        lf.pfd_up = 1'b1;
        tick(16);  chk("t5_up16", 140, 0);
        lf.pfd_up = 1'b0;
        tick(1);   chk("t5_settle", 132, 0);
        tick(302); chk("t5_prelock", 132, 0);
        tick(1);   chk("t5_lock", 132, 1);
        lf.pfd_up = 1'b1;
        tick(1);   chk("t5_track_step", 136, 1);
        lf.pfd_up = 1'b0;
        tick(1);   chk("t5_track_back", 132, 1);
        track_code = 132;
`else
        lf.pfd_up = 1'b0;
        lf.vco_ready = 1'b1;
        tick(1);  chk("t2_acq_entry", 128, 0);
        lf.pfd_up = 1'b1;
        tick(15); chk("t2_up15", 132, 0);
        tick(1);  chk("t2_up16", 133, 0);
        lf.pfd_up = 1'b0;
        tick(1);  chk("t2_idle", 129, 0);
        lf.pfd_dn = 1'b1;
        tick(1);  chk("t2_dn1", 124, 0);
        lf.pfd_up = 1'b1;
        tick(1);  chk("t2_both", 128, 0);
        lf.pfd_up = 1'b0;
        lf.pfd_dn = 1'b0;
        tick(1);  chk("t2_zero", 128, 0);

        lf.pfd_up = 1'b1;
        tick(3000); chk("t3_sat_hi", 255, 0);
        lf.pfd_up = 1'b0;
        tick(1);    chk("t3_acc_max", 255, 0);
        lf.pfd_dn = 1'b1;
        tick(1);    chk("t3_dn_from_max", 251, 0);
        tick(4999); chk("t3_sat_lo", 0, 0);
        lf.pfd_dn = 1'b0;
        tick(1);    chk("t3_acc_zero", 0, 0);
        lf.pfd_up = 1'b1;
        tick(1);    chk("t3_no_wrap", 4, 0);

        lf.pfd_up = 1'b0;
        lf.vco_ready = 1'b0;
        tick(1);   chk("t4_hold_wait", 4, 0);
        lf.vco_ready = 1'b1;
        tick(1);   chk("t4_acq_entry", 4, 0);
        tick(255); chk("t4_edge255", 0, 0);
        tick(1);   chk("t4_edge256", 0, 1);
        lf.pfd_up = 1'b1;
        tick(63);  chk("t4_up63", 8, 1);
        tick(1);   chk("t4_up64_unlock", 8, 0);
        lf.pfd_up = 1'b0;
        tick(255); chk("t4_relock_pre", 4, 0);
        tick(1);   chk("t4_relock", 4, 1);
        track_code = 4;
`endif

        lf.vco_ready = 1'b0;
        tick(1);   chk("t6_ready_drop", track_code, 0);
        lf.vco_ready = 1'b1;
        tick(1);   chk("t6_reacq", track_code, 0);
        tick(255); chk("t6_prelock", track_code, 0);
        tick(1);   chk("t6_lock", track_code, 1);
        lf.enable = 1'b0;
        tick(1);   chk("t6_disable", 128, 0);
        lf.enable = 1'b1;
        tick(1);   chk("t6_wait", 128, 0);
        tick(1);   chk("t6_acq", 128, 0);
        lf.pfd_up = 1'b1;
        tick(1);   chk("t6_acq_step", 128 + KP_ACQ, 0);
        lf.pfd_up = 1'b0;

        repeat (4) @(posedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
